// File: rtl/cpu_run_ctrl.sv
// Run controller for the 16-bit core: sequences core reset, gates execution with a
// clock enable (free-run / run-N / single-step, rate-divided) and counts issued cycles.
module cpu_run_ctrl #(
  parameter int CNT_W      = 32,
  parameter int DIV_W      = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  input  logic             clr_cnt,
  input  logic [CNT_W-1:0] run_len,
  input  logic [DIV_W-1:0] div,
  input  logic             halt_in,
  output logic             core_rst_n,
  output logic             core_ce,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [2:0]       state_o
);

  localparam int RW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_IDLE = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t           state_q;
  logic [RW-1:0]    rst_cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mode1_q;
  logic             core_rst_n_q;
  logic             core_ce_q;
  logic             busy_q;
  logic             done_q;

  logic             start_ok_d;
  logic             abort_d;
  logic             tick_d;
  logic [CNT_W-1:0] cnt_inc_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + {{(CNT_W-1){1'b0}}, 1'b1});
  endfunction

  // stop beats a coincident start; mode 3 is reserved and never starts a run
  assign start_ok_d = start && !stop && (mode != 2'd3);
  assign abort_d    = stop || halt_in;
  assign tick_d     = (div_cnt_q == div_q);
  assign cnt_inc_d  = sat_inc(cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RST;
      rst_cnt_q    <= '0;
      div_q        <= '0;
      div_cnt_q    <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      mode1_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
      core_ce_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      core_ce_q <= 1'b0;
      case (state_q)
        S_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q      <= S_IDLE;
            core_rst_n_q <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        S_IDLE, S_HALT: begin
          if (clr_cnt) cnt_q <= '0;
          if (start_ok_d) begin
            if (mode == 2'd2) begin
              state_q <= S_STEP;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else if ((mode == 2'd1) && (run_len == '0)) begin
              // zero-length run completes without ever enabling the core
              state_q <= S_HALT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RUN;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              div_q     <= div;
              div_cnt_q <= '0;
              rem_q     <= run_len;
              mode1_q   <= (mode == 2'd1);
            end
          end
        end
        S_RUN: begin
          if (abort_d) begin
            state_q <= S_HALT;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (tick_d) begin
            div_cnt_q <= '0;
            core_ce_q <= 1'b1;
            cnt_q     <= cnt_inc_d;
            if (mode1_q) begin
              rem_q <= rem_q - 1'b1;
              // the final pulse and the move to HALTED share one edge
              if (rem_q == CNT_W'(1)) begin
                state_q <= S_HALT;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        S_STEP: begin
          if (!abort_d) begin
            core_ce_q <= 1'b1;
            cnt_q     <= cnt_inc_d;
          end
          state_q <= S_HALT;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q      <= S_RST;
          rst_cnt_q    <= '0;
          core_rst_n_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign core_ce    = core_ce_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cycle_cnt  = cnt_q;
  assign state_o    = state_q;

endmodule
